// File: rtl/load_use_interlock.sv
// Producer-side hazard tracker: follows EX/MEM/WB destination info for the forwarding unit,
// raises the single-cycle load-use interlock and memory-wait holds, and counts stalls.
module load_use_interlock #(
   parameter int CNT_W    = 32,
   parameter int LU_CNT_W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                id_valid,
   input  logic [4:0]          id_rs1,
   input  logic [4:0]          id_rs2,
   input  logic                id_rs1_used,
   input  logic                id_rs2_used,
   input  logic [4:0]          id_rd,
   input  logic                id_reg_write,
   input  logic                id_is_load,
   input  logic                flush,
   input  logic                mem_wait,
   output logic                stall_if,
   output logic                stall_id,
   output logic                bubble_ex,
   output logic [4:0]          destination_reg_stage2,
   output logic                write_reg_stage2,
   output logic [4:0]          destination_reg_stage3,
   output logic                write_reg_stage3,
   output logic [CNT_W-1:0]    stall_cycles,
   output logic [LU_CNT_W-1:0] load_use_events
);

   logic                r_ex_valid, r_ex_wr, r_ex_load;
   logic [4:0]          r_ex_rd;
   logic                r_mem_valid, r_mem_wr, r_mem_load;
   logic [4:0]          r_mem_rd;
   logic                r_wb_valid, r_wb_wr, r_wb_load;
   logic [4:0]          r_wb_rd;
   logic                r_flush_pend;
   logic [CNT_W-1:0]    r_stall_cycles;
   logic [LU_CNT_W-1:0] r_lu_events;

   logic w_load_use, w_hold, w_kill, w_stall, w_bubble, w_lu_inc;

   always_comb begin
      w_load_use = r_ex_valid & r_ex_load & r_ex_wr & (r_ex_rd != 5'd0) & id_valid &
                   ((id_rs1_used & (id_rs1 == r_ex_rd)) | (id_rs2_used & (id_rs2 == r_ex_rd)));
      w_hold   = 1'b0;
      w_kill   = 1'b0;
      w_stall  = 1'b0;
      w_bubble = 1'b0;
      w_lu_inc = 1'b0;
      if (mem_wait) begin
         w_hold  = 1'b1;
         w_stall = 1'b1;
      end else if (flush | r_flush_pend) begin
         // the dependent instruction is being killed, so no interlock is needed
         w_kill   = 1'b1;
         w_bubble = 1'b1;
      end else if (w_load_use) begin
         w_kill   = 1'b1;
         w_stall  = 1'b1;
         w_bubble = 1'b1;
         w_lu_inc = 1'b1;
      end
   end

   // Gate with reset so the controls drop the instant reset is asserted.
   assign stall_if  = w_stall & reset_n;
   assign stall_id  = w_stall & reset_n;
   assign bubble_ex = w_bubble & reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {r_ex_valid, r_ex_rd, r_ex_wr, r_ex_load}     <= '0;
         {r_mem_valid, r_mem_rd, r_mem_wr, r_mem_load} <= '0;
         {r_wb_valid, r_wb_rd, r_wb_wr, r_wb_load}     <= '0;
         r_flush_pend   <= 1'b0;
         r_stall_cycles <= '0;
         r_lu_events    <= '0;
      end else begin
         if (!w_hold) begin
            {r_wb_valid, r_wb_rd, r_wb_wr, r_wb_load}     <= {r_mem_valid, r_mem_rd, r_mem_wr, r_mem_load};
            {r_mem_valid, r_mem_rd, r_mem_wr, r_mem_load} <= {r_ex_valid, r_ex_rd, r_ex_wr, r_ex_load};
            if (w_kill)
               {r_ex_valid, r_ex_rd, r_ex_wr, r_ex_load} <= '0;
            else
               {r_ex_valid, r_ex_rd, r_ex_wr, r_ex_load} <= {id_valid, id_rd, id_reg_write, id_is_load};
         end
         // a flush seen during a memory wait is replayed on the first free cycle
         if (mem_wait) begin
            if (flush) r_flush_pend <= 1'b1;
         end else begin
            r_flush_pend <= 1'b0;
         end
         if (w_stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if (w_lu_inc && (r_lu_events != '1))
            r_lu_events <= r_lu_events + LU_CNT_W'(1);
      end
   end

   assign destination_reg_stage2 = r_mem_rd;
   assign write_reg_stage2       = r_mem_valid & r_mem_wr & (r_mem_rd != 5'd0);
   assign destination_reg_stage3 = r_wb_rd;
   assign write_reg_stage3       = r_wb_valid & r_wb_wr & (r_wb_rd != 5'd0);
   assign stall_cycles           = r_stall_cycles;
   assign load_use_events        = r_lu_events;

endmodule

// File: tb/tb_load_use_interlock.sv
// Directed bench for load_use_interlock with small counters so saturation is reachable.
module tb_load_use_interlock;
   localparam int CNT_W    = 4;
   localparam int LU_CNT_W = 3;

   logic clk = 1'b0;
   logic reset_n;
   logic id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load, flush, mem_wait;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic stall_if, stall_id, bubble_ex, write_reg_stage2, write_reg_stage3;
   logic [4:0] destination_reg_stage2, destination_reg_stage3;
   logic [CNT_W-1:0]    stall_cycles;
   logic [LU_CNT_W-1:0] load_use_events;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   load_use_interlock #(.CNT_W(CNT_W), .LU_CNT_W(LU_CNT_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .flush(flush), .mem_wait(mem_wait),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
      .destination_reg_stage2(destination_reg_stage2), .write_reg_stage2(write_reg_stage2),
      .destination_reg_stage3(destination_reg_stage3), .write_reg_stage3(write_reg_stage3),
      .stall_cycles(stall_cycles), .load_use_events(load_use_events)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wr, input logic ld);
      id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
      id_rd = rd; id_reg_write = wr; id_is_load = ld;
   endtask

   task automatic nop();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; mem_wait = 1'b1;
      nop();
      #1;
      chk("rst_stall_id", stall_id, 0);
      chk("rst_stall_if", stall_if, 0);
      chk("rst_bubble", bubble_ex, 0);
      chk("rst_wr2", write_reg_stage2, 0);
      chk("rst_wr3", write_reg_stage3, 0);
      chk("rst_sc", stall_cycles, 0);
      chk("rst_lu", load_use_events, 0);
      mem_wait = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      tick();

      // lw x5 then add x6,x5,x1
      set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
      @(negedge clk); chk("lw_nostall", stall_id, 0);
      tick();
      set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
      @(negedge clk);
      chk("lu_stall_if", stall_if, 1);
      chk("lu_stall_id", stall_id, 1);
      chk("lu_bubble", bubble_ex, 1);
      tick();
      @(negedge clk);
      chk("lu_once", stall_id, 0);
      chk("lu_wr2", write_reg_stage2, 1);
      chk("lu_dst2", destination_reg_stage2, 5);
      chk("lu_cnt1", load_use_events, 1);
      chk("lu_sc1", stall_cycles, 1);
      tick();
      nop();
      @(negedge clk);
      chk("lu_wr3", write_reg_stage3, 1);
      chk("lu_dst3", destination_reg_stage3, 5);
      chk("lu_bubble_wr2", write_reg_stage2, 0);
      tick();

      // lw x0 then reader of x0
      set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1);
      tick();
      set_id(1, 5'd0, 1, 5'd0, 1, 5'd6, 1, 0);
      @(negedge clk); chk("x0_nostall", stall_id, 0);
      tick();
      nop();
      @(negedge clk); chk("x0_wr2", write_reg_stage2, 0);
      tick();

      // load-use coinciding with flush
      set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
      tick();
      set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
      flush = 1'b1;
      @(negedge clk);
      chk("fl_bubble", bubble_ex, 1);
      chk("fl_stall_id", stall_id, 0);
      chk("fl_stall_if", stall_if, 0);
      tick();
      flush = 1'b0; nop();
      @(negedge clk);
      chk("fl_lu_same", load_use_events, 1);
      chk("fl_wr2", write_reg_stage2, 1);
      chk("fl_sc", stall_cycles, 1);
      tick(); tick(); tick();

      // mem_wait 3 cycles with flush pulsed in the second
      set_id(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 0);
      tick();
      nop(); mem_wait = 1'b1;
      @(negedge clk);
      chk("mw1_stall", stall_id, 1);
      chk("mw1_bubble", bubble_ex, 0);
      tick();
      flush = 1'b1;
      @(negedge clk); chk("mw2_stall", stall_id, 1);
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("mw3_stall_if", stall_if, 1);
      chk("mw3_frozen", write_reg_stage2, 0);
      tick();
      mem_wait = 1'b0;
      set_id(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 0);
      @(negedge clk);
      chk("mw_free_bubble", bubble_ex, 1);
      chk("mw_free_stall", stall_id, 0);
      chk("mw_sc", stall_cycles, 4);
      tick();
      nop();
      @(negedge clk);
      chk("mw_dst2", destination_reg_stage2, 9);
      chk("mw_wr2", write_reg_stage2, 1);
      chk("mw_pend_clr", bubble_ex, 0);
      tick();
      @(negedge clk);
      chk("mw_dst3", destination_reg_stage3, 9);
      chk("mw_wr3", write_reg_stage3, 1);
      chk("mw_killed", write_reg_stage2, 0);
      tick();

      // non-load producer: forwarding path, no stall
      set_id(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 0);
      tick();
      set_id(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
      @(negedge clk);
      chk("alu_nostall", stall_id, 0);
      chk("alu_nobubble", bubble_ex, 0);
      tick();
      nop();
      @(negedge clk);
      chk("alu_dst2", destination_reg_stage2, 7);
      chk("alu_wr2", write_reg_stage2, 1);
      tick();
      @(negedge clk);
      chk("alu_dst3", destination_reg_stage3, 7);
      chk("alu_wr3", write_reg_stage3, 1);
      tick();

      // source-used qualifiers
      set_id(1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1);
      tick();
      set_id(1, 5'd4, 0, 5'd1, 1, 5'd8, 1, 0);
      @(negedge clk); chk("unused_rs1", stall_id, 0);
      tick();
      set_id(1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1);
      tick();
      set_id(1, 5'd0, 0, 5'd4, 1, 5'd8, 1, 0);
      @(negedge clk); chk("rs2_stall", stall_id, 1);
      tick();
      nop();
      @(negedge clk); chk("rs2_lu", load_use_events, 2);
      tick();

      // six more load-use events saturate the 3-bit counter at 7
      for (int i = 0; i < 6; i++) begin
         set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
         tick();
         set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
         tick();
         tick();
      end
      nop();
      @(negedge clk);
      chk("lu_sat", load_use_events, 7);
      chk("sc_11", stall_cycles, 11);
      tick();

      // stall_cycles saturation and reset during a stall
      mem_wait = 1'b1;
      tick(); tick(); tick();
      @(negedge clk); chk("sc_14", stall_cycles, 14);
      tick(); tick(); tick(); tick();
      @(negedge clk); chk("sc_sat", stall_cycles, 15);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_stall_id", stall_id, 0);
      chk("arst_stall_if", stall_if, 0);
      chk("arst_sc", stall_cycles, 0);
      chk("arst_lu", load_use_events, 0);
      chk("arst_wr2", write_reg_stage2, 0);
      chk("arst_wr3", write_reg_stage3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
